// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle with a fixed
// 33-cycle latency, writing back through the register-file port signals.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        we
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, nextState;
  logic [4:0]  count;
  logic        setup;
  logic [2:0]  fn;
  logic [31:0] opA, opB, addend;
  logic [4:0]  rdLat;
  logic [63:0] prod;

  logic        isDiv, aSigned, bSigned, negA, negB, divZero, accept;
  logic [31:0] magA, magB;
  logic [32:0] addSum, remShift, diff;
  logic [63:0] stepProd, fullProd;
  logic [31:0] quo, remv, finalRes;

  // Signedness per op; divide ops are signed when funct3[0] is clear.
  always_comb begin
    isDiv   = fn[2];
    aSigned = isDiv ? ~fn[0] : (fn == 3'b001 || fn == 3'b010);
    bSigned = isDiv ? ~fn[0] : (fn == 3'b001);
    negA    = aSigned & opA[31];
    negB    = bSigned & opB[31];
    magA    = negA ? -opA : opA;
    magB    = negB ? -opB : opB;
    divZero = isDiv && (opB == 32'd0);
    accept  = start && (state != CALC);
    busy    = (state == CALC);
  end

  // prod holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    addSum   = {1'b0, prod[63:32]} + {1'b0, (prod[0] ? addend : 32'd0)};
    remShift = {prod[63:32], prod[31]};
    diff     = remShift - {1'b0, addend};
    if (isDiv) begin
      if (diff[32])
        stepProd = {remShift[31:0], prod[30:0], 1'b0};
      else
        stepProd = {diff[31:0], prod[30:0], 1'b1};
    end else begin
      stepProd = {addSum, prod[31:1]};
    end
  end

  // Sign fix-up on the final step's output, plus divide-by-zero overrides.
  always_comb begin
    fullProd = (negA ^ negB) ? -stepProd : stepProd;
    quo      = stepProd[31:0];
    remv     = stepProd[63:32];
    finalRes = 32'd0;
    case (fn)
      3'b000:                 finalRes = fullProd[31:0];
      3'b001, 3'b010, 3'b011: finalRes = fullProd[63:32];
      3'b100, 3'b101:         finalRes = divZero ? 32'hFFFF_FFFF : ((negA ^ negB) ? -quo : quo);
      default:                finalRes = divZero ? opA : (negA ? -remv : remv);
    endcase
  end

  // The setup cycle spends one CALC cycle loading magnitudes before the 32 steps.
  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: nextState = start ? CALC : IDLE;
      CALC:       nextState = (!setup && count == 5'd31) ? DONE : CALC;
      default:    nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= 5'd0;
      setup  <= 1'b0;
      fn     <= 3'd0;
      opA    <= 32'd0;
      opB    <= 32'd0;
      addend <= 32'd0;
      rdLat  <= 5'd0;
      prod   <= 64'd0;
      done   <= 1'b0;
      we     <= 1'b0;
      result <= 32'd0;
      rd_out <= 5'd0;
    end else begin
      state <= nextState;
      done  <= (nextState == DONE);
      we    <= (nextState == DONE) && (rdLat != 5'd0);
      if (accept) begin
        fn    <= funct3;
        opA   <= op_a;
        opB   <= op_b;
        rdLat <= rd_in;
        count <= 5'd0;
        setup <= 1'b1;
      end else if (state == CALC) begin
        if (setup) begin
          setup  <= 1'b0;
          prod   <= {32'd0, (isDiv ? magA : magB)};
          addend <= isDiv ? magB : magA;
        end else begin
          prod  <= stepProd;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            result <= finalRes;
            rd_out <= rdLat;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: table of ops with hand-computed results
// plus sequences for back-to-back starts and reset during a calculation.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, we;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[21];

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .we(we)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accepts one op on the next posedge, then scrambles the inputs.
  task automatic applyStimulus(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; funct3 = fn; op_a = a; op_b = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; op_a = ~a; op_b = b ^ 32'h5A5A_5A5A; rd_in = ~rd; funct3 = ~fn;
    checkValue("busy after accept", {31'd0, busy}, 32'd1);
  endtask

  // Called #1 after the accept edge; done must appear exactly 33 edges later.
  task automatic checkOutput(input string name, input logic [31:0] expRes, input logic [4:0] expRd);
    int early = 0;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      if (done) early++;
    end
    checkValue({name, " early done"}, early, 0);
    @(posedge clk); #1;
    checkValue({name, " done"}, {31'd0, done}, 32'd1);
    checkValue({name, " result"}, result, expRes);
    checkValue({name, " rd_out"}, {27'd0, rd_out}, {27'd0, expRd});
    checkValue({name, " we"}, {31'd0, we}, {31'd0, (expRd != 5'd0)});
    @(posedge clk); #1;
    checkValue({name, " done low"}, {29'd0, done, we, busy}, 32'd0);
    checkValue({name, " result hold"}, result, expRes);
  endtask

  initial begin
    int cnt;

    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE};
    vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF};
    vecs[6]  = '{3'b101, 32'd100,       32'd0,         5'd11, 32'hFFFF_FFFF};
    vecs[7]  = '{3'b111, 32'd100,       32'd0,         5'd12, 32'd100};
    vecs[8]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000};
    vecs[9]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000};
    vecs[10] = '{3'b000, 32'h1234_5678, 32'h0000_0010, 5'd15, 32'h2345_6780};
    vecs[11] = '{3'b011, 32'h8000_0000, 32'h0000_0004, 5'd16, 32'h0000_0002};
    vecs[12] = '{3'b101, 32'd100,       32'd7,         5'd17, 32'd14};
    vecs[13] = '{3'b111, 32'd100,       32'd7,         5'd18, 32'd2};
    vecs[14] = '{3'b100, 32'd20,        32'hFFFF_FFFA, 5'd19, 32'hFFFF_FFFD};
    vecs[15] = '{3'b110, 32'd20,        32'hFFFF_FFFA, 5'd20, 32'd2};
    vecs[16] = '{3'b100, 32'hFFFF_FFFB, 32'd0,         5'd21, 32'hFFFF_FFFF};
    vecs[17] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         5'd22, 32'hFFFF_FFFB};
    vecs[18] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd23, 32'h4000_0000};
    vecs[19] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd24, 32'h8000_0000};
    vecs[20] = '{3'b000, 32'd6,         32'd7,         5'd0,  32'd42};

    rst_n = 1'b0; start = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    #12;
    checkValue("reset outputs", {27'd0, busy, done, we, 2'b00}, 32'd0);
    checkValue("reset result", result, 32'd0);
    checkValue("reset rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].rd);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp, vecs[i].rd);
    end

    // start held for 40 cycles; inputs switch to a DIVU while the MUL is busy
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; rd_in = 5'd1;
    @(posedge clk);
    cnt = 0;
    for (int i = 1; i <= 68; i++) begin
      @(posedge clk); #1;
      if (done) cnt++;
      if (i == 5) begin
        funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd8; rd_in = 5'd2;
      end
      if (i == 33) begin
        checkValue("b2b first done", {31'd0, done}, 32'd1);
        checkValue("b2b first result", result, 32'd15);
        checkValue("b2b first rd_out", {27'd0, rd_out}, 32'd1);
      end
      if (i == 34) checkValue("b2b second accepted", {30'd0, busy, done}, 32'd2);
      if (i == 40) start = 1'b0;
      if (i == 67) begin
        checkValue("b2b second done", {31'd0, done}, 32'd1);
        checkValue("b2b second result", result, 32'd125);
        checkValue("b2b second rd_out", {27'd0, rd_out}, 32'd2);
      end
      if (i == 68) checkValue("b2b idle after", {30'd0, busy, done}, 32'd0);
    end
    checkValue("b2b done pulse count", cnt, 2);

    // reset at cycle 10 of CALC aborts the op
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkValue("abort outputs", {27'd0, busy, done, we, 2'b00}, 32'd0);
    checkValue("abort result", result, 32'd0);
    checkValue("abort rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || we || busy) cnt++;
    end
    checkValue("abort no done", cnt, 0);
    applyStimulus(3'b000, 32'd9, 32'd9, 5'd4);
    checkOutput("after abort", 32'd81, 5'd4);

    // start honoured on the first edge after reset release
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; funct3 = 3'b101; op_a = 32'd50; op_b = 32'd5; rd_in = 5'd31;
    @(posedge clk); #1;
    start = 1'b0;
    checkValue("first edge accept", {31'd0, busy}, 32'd1);
    checkOutput("post reset", 32'd10, 5'd31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
